// File: rtl/uart_ram_pkg.sv
// rtl/uart_ram_pkg.sv - shared types and constants for the UART RAM command decoder
package uart_ram_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_HI = 4'd1,
    ADDR_LO = 4'd2,
    WRITE   = 4'd3,
    LEN     = 4'd4,
    RD_REQ  = 4'd5,
    RD_WAIT = 4'd6,
    RD_SEND = 4'd7,
    ERR     = 4'd8
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam int         LEN_W     = 9;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_ram_cmd.sv
// rtl/uart_ram_cmd.sv - parses UART command bytes into RAM writes and streamed RAM reads
module uart_ram_cmd
  import uart_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_timeout,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              cmd_err
);

  state_t             state, state_d;
  logic               mode_rd, mode_rd_d;
  logic [ADDR_W-1:0]  addr, addr_d;
  logic [LEN_W-1:0]   count, count_d;
  logic               ram_en_d, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_d;
  logic [7:0]         tx_data_d;
  logic               tx_valid_d;
  logic               cmd_err_d;
  logic [15:0]        addr_wide;
  logic               tx_accept;

  assign addr_wide = 16'(addr);
  assign tx_accept = tx_valid && tx_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // A timeout aborts any parse state, but a read in progress always completes.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (rx_valid) state_d = is_cmd(rx_data) ? ADDR_HI : ERR;
      ADDR_HI: if (rx_timeout) state_d = IDLE;
               else if (rx_valid) state_d = ADDR_LO;
      ADDR_LO: if (rx_timeout) state_d = IDLE;
               else if (rx_valid) state_d = mode_rd ? LEN : WRITE;
      WRITE:   if (rx_timeout) state_d = IDLE;
      LEN:     if (rx_timeout) state_d = IDLE;
               else if (rx_valid) state_d = RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = RD_SEND;
      RD_SEND: if (tx_accept) state_d = (count == LEN_W'(1)) ? IDLE : RD_REQ;
      ERR:     if (rx_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_rd_d   = mode_rd;
    addr_d      = addr;
    count_d     = count;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    cmd_err_d   = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        mode_rd_d = (rx_data == CMD_READ);
        cmd_err_d = !is_cmd(rx_data);
      end
      ADDR_HI: if (rx_valid) addr_d = ADDR_W'({rx_data, addr_wide[7:0]});
      ADDR_LO: if (rx_valid) addr_d = ADDR_W'({addr_wide[15:8], rx_data});
      WRITE: if (rx_valid) begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = addr;
        ram_wdata_d = DATA_W'(rx_data);
        addr_d      = addr + ADDR_W'(1);
      end
      LEN: if (rx_valid) count_d = (rx_data == 8'h00) ? LEN_W'(256) : LEN_W'(rx_data);
      RD_WAIT: begin
        tx_data_d  = 8'(ram_rdata);
        tx_valid_d = 1'b1;
      end
      RD_SEND: if (tx_accept) begin
        tx_valid_d = 1'b0;
        count_d    = count - LEN_W'(1);
        addr_d     = addr + ADDR_W'(1);
      end
      default: ;
    endcase
    // The read strobe is registered so it is high exactly while in RD_REQ.
    if (state_d == RD_REQ) begin
      ram_en_d   = 1'b1;
      ram_we_d   = 1'b0;
      ram_addr_d = addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_rd   <= 1'b0;
      addr      <= '0;
      count     <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mode_rd   <= mode_rd_d;
      addr      <= addr_d;
      count     <= count_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      cmd_err   <= cmd_err_d;
    end
  end

endmodule
